// File: rtl/decode_output_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// decode_output_arbiter_pkg
// Shared decode definitions used by the format decoders, the output arbiter
// and dispatch: ID widths, functional-unit codes and the bit layout of the
// packed decoded payload (the arbiter itself treats the payload as opaque).
// Optional feature macro affecting users of this package:
// DECODE_ARB_AGE_ORDER_EN (age-ordered grant in decode_arb_select).
// -----------------------------------------------------------------------------
package decode_output_arbiter_pkg;

  // Instruction identity: 64-bit major counter (never wraps) + minor index.
  localparam int DecInstCounterWidth = 64;
  localparam int DecInstMinIdWidth   = 7;
  localparam int DecPayloadWidth     = 160;

  // Functional-unit codes carried in the payload.
  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_DIV = 3'd2,
    FU_LSU = 3'd3,
    FU_BRU = 3'd4,
    FU_FPU = 3'd5
  } fu_code_e;

  // Decoded-payload field layout (LSB offsets and widths).
  localparam int PayFuOffset    = 0;
  localparam int PayFuWidth     = 3;
  localparam int PayRdOffset    = 3;
  localparam int PayRdWidth     = 5;
  localparam int PayRs1Offset   = 8;
  localparam int PayRs1Width    = 5;
  localparam int PayRs2Offset   = 13;
  localparam int PayRs2Width    = 5;
  localparam int PayImmOffset   = 18;
  localparam int PayImmWidth    = 64;
  localparam int PayPcOffset    = 82;
  localparam int PayPcWidth     = 64;
  localparam int PayFlagsOffset = 146;
  localparam int PayFlagsWidth  = 14;

  // Extract the functional-unit code from a packed payload.
  function automatic fu_code_e payload_fu(input logic [DecPayloadWidth-1:0] pay);
    return fu_code_e'(pay[PayFuOffset +: PayFuWidth]);
  endfunction

endpackage

// File: rtl/decode_arb_select.sv
// -----------------------------------------------------------------------------
// decode_arb_select
// Combinational grant selection among full holding slots.
//   Default build        : round-robin, search from ptr_i upward with wrap.
//   DECODE_ARB_AGE_ORDER_EN : oldest slot wins (smallest major ID, then
//                          smallest minor ID, then lowest index); ptr_i unused.
// Ports:
//   slotFull_i    in  numReq              slot holds an instruction
//   ptr_i         in  reqIdxWidth         round-robin start index
//   slotMajId_i   in  numReq*majWidth     per-slot major IDs (slot k = slice k)
//   slotMinId_i   in  numReq*minWidth     per-slot minor IDs
//   grant_o       out numReq              one-hot grant (zero if no slot full)
//   grantIdx_o    out reqIdxWidth         encoded grant index
//   grantValid_o  out 1                   some slot was selected
// -----------------------------------------------------------------------------
module decode_arb_select
  import decode_output_arbiter_pkg::*;
#(
  parameter int numReq      = 4,
  parameter int reqIdxWidth = 2,
  parameter int majWidth    = DecInstCounterWidth,
  parameter int minWidth    = DecInstMinIdWidth
) (
  input  logic [numReq-1:0]          slotFull_i,
  input  logic [reqIdxWidth-1:0]     ptr_i,
  input  logic [numReq*majWidth-1:0] slotMajId_i,
  input  logic [numReq*minWidth-1:0] slotMinId_i,
  output logic [numReq-1:0]          grant_o,
  output logic [reqIdxWidth-1:0]     grantIdx_o,
  output logic                       grantValid_o
);

  localparam logic [numReq-1:0] OneHot = numReq'(1);

  logic                   found_s;
  logic [reqIdxWidth-1:0] sel_s;

`ifdef DECODE_ARB_AGE_ORDER_EN
  logic [majWidth-1:0] bestMaj_s;
  logic [minWidth-1:0] bestMin_s;
  logic                unused_ptr_s;

  assign unused_ptr_s = ^ptr_i;

  // Oldest-first scan; strict compares keep the lowest index on full ties.
  always_comb begin
    found_s   = 1'b0;
    sel_s     = '0;
    bestMaj_s = '0;
    bestMin_s = '0;
    for (int i = 0; i < numReq; i++) begin
      if (slotFull_i[i] &&
          (!found_s ||
           (slotMajId_i[i*majWidth +: majWidth] < bestMaj_s) ||
           ((slotMajId_i[i*majWidth +: majWidth] == bestMaj_s) &&
            (slotMinId_i[i*minWidth +: minWidth] < bestMin_s)))) begin
        found_s   = 1'b1;
        sel_s     = reqIdxWidth'(i);
        bestMaj_s = slotMajId_i[i*majWidth +: majWidth];
        bestMin_s = slotMinId_i[i*minWidth +: minWidth];
      end else begin
      end
    end
  end
`else
  logic unused_ids_s;

  assign unused_ids_s = ^{slotMajId_i, slotMinId_i};

  // Two-pass round-robin: first full slot at or above the pointer, otherwise
  // the lowest full slot (which is the wrap-around winner).
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    for (int i = 0; i < numReq; i++) begin
      if (!found_s && slotFull_i[i] && (reqIdxWidth'(i) >= ptr_i)) begin
        found_s = 1'b1;
        sel_s   = reqIdxWidth'(i);
      end else begin
      end
    end
    for (int i = 0; i < numReq; i++) begin
      if (!found_s && slotFull_i[i]) begin
        found_s = 1'b1;
        sel_s   = reqIdxWidth'(i);
      end else begin
      end
    end
  end
`endif

  assign grantValid_o = found_s;
  assign grantIdx_o   = sel_s;
  assign grant_o      = found_s ? (OneHot << sel_s) : '0;

endmodule

// File: rtl/decode_output_arbiter.sv
// -----------------------------------------------------------------------------
// decode_output_arbiter
// Merges decoded instructions from numReq format decoders into one registered
// decoded-instruction stream. Each requester owns a one-entry holding slot;
// one slot is granted per cycle into the output register when it can advance.
// Optional feature macro: DECODE_ARB_AGE_ORDER_EN (oldest-first grant instead
// of round-robin; handshake, latency and reset are unchanged).
// Ports:
//   clock_i       in  1                clock
//   reset_i       in  1                synchronous active-high reset
//   reqValid_i    in  numReq           requester k offers an instruction
//   reqMajId_i    in  numReq*64        major IDs, requester k = slice k
//   reqMinId_i    in  numReq*7         minor IDs
//   reqPayload_i  in  numReq*160       decoded payloads
//   reqStall_o    out numReq           requester k must hold (offer not taken)
//   stall_i       in  1                downstream cannot accept
//   outValid_o    out 1                output register valid
//   outMajId_o    out 64               forwarded major ID
//   outMinId_o    out 7                forwarded minor ID
//   outPayload_o  out 160              forwarded payload
//   outSrc_o      out reqIdxWidth      index of supplying requester
// -----------------------------------------------------------------------------
module decode_output_arbiter
  import decode_output_arbiter_pkg::*;
#(
  parameter int numReq                  = 4,
  parameter int reqIdxWidth             = 2,
  parameter int instructionCounterWidth = DecInstCounterWidth,
  parameter int instMinIdWidth          = DecInstMinIdWidth,
  parameter int payloadWidth            = DecPayloadWidth
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic [numReq-1:0]                    reqValid_i,
  input  logic [numReq*instructionCounterWidth-1:0] reqMajId_i,
  input  logic [numReq*instMinIdWidth-1:0]     reqMinId_i,
  input  logic [numReq*payloadWidth-1:0]       reqPayload_i,
  output logic [numReq-1:0]                    reqStall_o,
  input  logic                                 stall_i,
  output logic                                 outValid_o,
  output logic [instructionCounterWidth-1:0]   outMajId_o,
  output logic [instMinIdWidth-1:0]            outMinId_o,
  output logic [payloadWidth-1:0]              outPayload_o,
  output logic [reqIdxWidth-1:0]               outSrc_o
);

  logic [numReq-1:0]                               slotFull_q, slotFull_d;
  logic [numReq-1:0][instructionCounterWidth-1:0]  slotMaj_q, slotMaj_d;
  logic [numReq-1:0][instMinIdWidth-1:0]           slotMin_q, slotMin_d;
  logic [numReq-1:0][payloadWidth-1:0]             slotPay_q, slotPay_d;
  logic [reqIdxWidth-1:0]                          ptr_q, ptr_d;

  logic                               outValid_q, outValid_d;
  logic [instructionCounterWidth-1:0] outMaj_q, outMaj_d;
  logic [instMinIdWidth-1:0]          outMin_q, outMin_d;
  logic [payloadWidth-1:0]            outPay_q, outPay_d;
  logic [reqIdxWidth-1:0]             outSrc_q, outSrc_d;

  logic                   advance_s;
  logic [numReq-1:0]      selGrant_s;
  logic [numReq-1:0]      grant_s;
  logic [reqIdxWidth-1:0] grantIdx_s;
  logic                   selValid_s;
  logic [numReq-1:0]      stall_s;

  // The output register can take a new instruction when empty or draining.
  assign advance_s = ~outValid_q | ~stall_i;

  decode_arb_select #(
    .numReq      (numReq),
    .reqIdxWidth (reqIdxWidth),
    .majWidth    (instructionCounterWidth),
    .minWidth    (instMinIdWidth)
  ) u_select (
    .slotFull_i   (slotFull_q),
    .ptr_i        (ptr_q),
    .slotMajId_i  (slotMaj_q),
    .slotMinId_i  (slotMin_q),
    .grant_o      (selGrant_s),
    .grantIdx_o   (grantIdx_s),
    .grantValid_o (selValid_s)
  );

  // A selection only becomes a grant when the output register can move.
  assign grant_s    = advance_s ? selGrant_s : '0;
  assign stall_s    = slotFull_q & ~grant_s;
  assign reqStall_o = stall_s;

  // Slot next state: capture when empty or draining this edge, free on grant.
  always_comb begin
    slotFull_d = slotFull_q;
    slotMaj_d  = slotMaj_q;
    slotMin_d  = slotMin_q;
    slotPay_d  = slotPay_q;
    for (int k = 0; k < numReq; k++) begin
      if (reqValid_i[k] && !stall_s[k]) begin
        slotFull_d[k] = 1'b1;
        slotMaj_d[k]  = reqMajId_i[k*instructionCounterWidth +: instructionCounterWidth];
        slotMin_d[k]  = reqMinId_i[k*instMinIdWidth +: instMinIdWidth];
        slotPay_d[k]  = reqPayload_i[k*payloadWidth +: payloadWidth];
      end else if (grant_s[k]) begin
        slotFull_d[k] = 1'b0;
      end else begin
      end
    end
  end

  // Output register and round-robin pointer next state.
  always_comb begin
    outValid_d = outValid_q;
    outMaj_d   = outMaj_q;
    outMin_d   = outMin_q;
    outPay_d   = outPay_q;
    outSrc_d   = outSrc_q;
    ptr_d      = ptr_q;
    if (advance_s) begin
      if (selValid_s) begin
        outValid_d = 1'b1;
        outMaj_d   = slotMaj_q[grantIdx_s];
        outMin_d   = slotMin_q[grantIdx_s];
        outPay_d   = slotPay_q[grantIdx_s];
        outSrc_d   = grantIdx_s;
`ifndef DECODE_ARB_AGE_ORDER_EN
        if (grantIdx_s == reqIdxWidth'(numReq - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grantIdx_s + reqIdxWidth'(1);
        end
`endif
      end else begin
        outValid_d = 1'b0;
      end
    end else begin
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      slotFull_q <= '0;
      slotMaj_q  <= '0;
      slotMin_q  <= '0;
      slotPay_q  <= '0;
      ptr_q      <= '0;
      outValid_q <= 1'b0;
      outMaj_q   <= '0;
      outMin_q   <= '0;
      outPay_q   <= '0;
      outSrc_q   <= '0;
    end else begin
      slotFull_q <= slotFull_d;
      slotMaj_q  <= slotMaj_d;
      slotMin_q  <= slotMin_d;
      slotPay_q  <= slotPay_d;
      ptr_q      <= ptr_d;
      outValid_q <= outValid_d;
      outMaj_q   <= outMaj_d;
      outMin_q   <= outMin_d;
      outPay_q   <= outPay_d;
      outSrc_q   <= outSrc_d;
    end
  end

  assign outValid_o   = outValid_q;
  assign outMajId_o   = outMaj_q;
  assign outMinId_o   = outMin_q;
  assign outPayload_o = outPay_q;
  assign outSrc_o     = outSrc_q;

endmodule
